imem_program_loader: RTL and testbench

Boot-time loader sitting directly upstream of the monocycle processor. It receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into the instruction memory's write port and holds the processor in reset until the whole image has been written and a checksum verified. It replaces file-based instruction preloading, so the same image reaches the core in synthesis and in simulation.

---
 rtl/imem_program_loader.sv | 132 +++++++++++++
 tb/tb_imem_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream, writes 32-bit words
// into instruction memory, and keeps the core in reset until the XOR checksum matches.
module imem_program_loader #(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   localparam int unsigned CAP = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state, state_nx;
   logic              xfer;
   logic [15:0]       len;
   logic [15:0]       len_full;
   logic [ADDR_W:0]   word_cnt;
   logic [ADDR_W:0]   word_cnt_inc;
   logic [1:0]        byte_cnt;
   logic [7:0]        csum;
   logic [7:0]        csum_nx;
   logic [23:0]       asm_q;

   always_comb begin
      in_ready = (state == S_LEN0) || (state == S_LEN1) ||
                 (state == S_DATA) || (state == S_CSUM);
   end

   assign xfer = in_valid && in_ready;

   always_comb begin
      state_nx     = state;
      csum_nx      = csum ^ in_data;
      len_full     = {in_data, len[7:0]};
      word_cnt_inc = word_cnt + (ADDR_W+1)'(1);
      case (state)
         S_LEN0: if (xfer) state_nx = S_LEN1;
         S_LEN1: begin
            if (xfer) begin
               if (32'(len_full) > CAP)  state_nx = S_ERR;
               else if (len_full == '0)  state_nx = S_CSUM;
               else                      state_nx = S_DATA;
            end
         end
         S_DATA: begin
            // The word count is compared post-increment so CSUM follows the last byte directly.
            if (xfer && byte_cnt == 2'd3 && 32'(word_cnt_inc) == 32'(len))
               state_nx = S_CSUM;
         end
         S_CSUM: begin
            if (xfer) state_nx = (in_data == csum) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: if (reload) state_nx = S_LEN0;
         default: state_nx = S_LEN0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_LEN0;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len        <= '0;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         csum       <= '0;
         asm_q      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         done    <= (state_nx == S_DONE);
         error   <= (state_nx == S_ERR);
         cpu_rst <= (state_nx != S_DONE);
         case (state)
            S_LEN0: if (xfer) len[7:0] <= in_data;
            S_LEN1: if (xfer) len <= len_full;
            S_DATA: begin
               if (xfer) begin
                  csum     <= csum_nx;
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: asm_q[7:0]   <= in_data;
                     2'd1: asm_q[15:8]  <= in_data;
                     2'd2: asm_q[23:16] <= in_data;
                     default: begin
                        imem_wdata <= {in_data, asm_q};
                        imem_addr  <= word_cnt[ADDR_W-1:0];
                        imem_we    <= 1'b1;
                        word_cnt   <= word_cnt_inc;
                     end
                  endcase
               end
            end
            S_DONE, S_ERR: begin
               if (reload) begin
                  len      <= '0;
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  csum     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: nominal, bad checksum, overflow, empty, full,
// gapped and mid-stream reset loads, all checked against hand-computed values.
module tb_imem_program_loader;

   localparam int unsigned ADDR_W = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_ready;
   logic              reload = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              error;

   int n_cmp = 0;
   int n_err = 0;
   int acc_cnt = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [7:0]  stim[$];

   always #5 clk = ~clk;

   imem_program_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .error      (error)
   );

   // Mid-cycle observer: records memory writes and bytes about to be consumed.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(32'(imem_addr));
         wr_data.push_back(imem_wdata);
      end
      if (in_valid && in_ready && !rst) acc_cnt <= acc_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_stim(input int max_gap);
      foreach (stim[i]) send_byte(stim[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0)));
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic set_nominal(input logic [7:0] cs);
      stim = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, cs};
   endtask

   task automatic check_nominal_writes(input string tag);
      check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
      check({tag, "_a0"}, wr_addr[0], 32'd0);
      check({tag, "_d0"}, wr_data[0], 32'h0050_0093);
      check({tag, "_a1"}, wr_addr[1], 32'd1);
      check({tag, "_d1"}, wr_data[1], 32'h00A0_0113);
   endtask

   initial begin
      int a0;
      do_reset(2);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);

      // Nominal back-to-back load with per-byte timing checks.
      wr_addr.delete(); wr_data.delete();
      set_nominal(8'h71);
      for (int i = 0; i < 11; i++) begin
         send_byte(stim[i], 0);
         if (i == 5) begin
            check("nom_we0", 32'(imem_we), 32'd1);
            check("nom_addr0", 32'(imem_addr), 32'd0);
            check("nom_wdata0", imem_wdata, 32'h0050_0093);
         end
         if (i == 6) check("nom_we_pulse", 32'(imem_we), 32'd0);
         if (i == 9) begin
            check("nom_we1", 32'(imem_we), 32'd1);
            check("nom_pre_cpu_rst", 32'(cpu_rst), 32'd1);
            check("nom_pre_done", 32'(done), 32'd0);
         end
      end
      check("nom_done", 32'(done), 32'd1);
      check("nom_cpu_rst", 32'(cpu_rst), 32'd0);
      check("nom_error", 32'(error), 32'd0);
      check("nom_in_ready", 32'(in_ready), 32'd0);
      check_nominal_writes("nom");
      pulse_reload();
      check("nom_rl_cpu_rst", 32'(cpu_rst), 32'd1);
      check("nom_rl_done", 32'(done), 32'd0);
      check("nom_rl_in_ready", 32'(in_ready), 32'd1);

      // Bad checksum.
      wr_addr.delete(); wr_data.delete();
      set_nominal(8'h72);
      run_stim(0);
      check("bad_error", 32'(error), 32'd1);
      check("bad_done", 32'(done), 32'd0);
      check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("bad_in_ready", 32'(in_ready), 32'd0);
      check_nominal_writes("bad");
      pulse_reload();

      // Length overflow, N = 65.
      wr_addr.delete(); wr_data.delete();
      stim = {8'h41, 8'h00};
      run_stim(0);
      check("ovf_error", 32'(error), 32'd1);
      check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("ovf_in_ready", 32'(in_ready), 32'd0);
      check("ovf_nwr", 32'(wr_addr.size()), 32'd0);
      pulse_reload();

      // Empty image, then extra bytes offered while not ready.
      wr_addr.delete(); wr_data.delete();
      stim = {8'h00, 8'h00, 8'h00};
      run_stim(0);
      check("empty_done", 32'(done), 32'd1);
      check("empty_cpu_rst", 32'(cpu_rst), 32'd0);
      a0 = acc_cnt;
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("empty_no_accept", 32'(acc_cnt), 32'(a0));
      check("empty_in_ready", 32'(in_ready), 32'd0);
      check("empty_done_hold", 32'(done), 32'd1);
      check("empty_nwr", 32'(wr_addr.size()), 32'd0);
      @(posedge clk);
      #1;
      pulse_reload();

      // Full memory, N = 64; data byte k = k, XOR of 0..255 is 0.
      wr_addr.delete(); wr_data.delete();
      stim = {8'h40, 8'h00};
      for (int k = 0; k < 256; k++) stim.push_back(8'(k));
      stim.push_back(8'h00);
      run_stim(0);
      check("full_done", 32'(done), 32'd1);
      check("full_nwr", 32'(wr_addr.size()), 32'd64);
      check("full_d0", wr_data[0], 32'h0302_0100);
      check("full_a63", wr_addr[63], 32'd63);
      check("full_d63", wr_data[63], 32'hFFFE_FDFC);
      pulse_reload();

      // Nominal with random idle gaps.
      wr_addr.delete(); wr_data.delete();
      a0 = acc_cnt;
      set_nominal(8'h71);
      run_stim(3);
      @(negedge clk);
      check("gap_accepted", 32'(acc_cnt - a0), 32'd11);
      check("gap_done", 32'(done), 32'd1);
      check_nominal_writes("gap");
      @(posedge clk);
      #1;
      pulse_reload();

      // Reset after 6 data bytes, then a full resend.
      wr_addr.delete(); wr_data.delete();
      set_nominal(8'h71);
      for (int i = 0; i < 8; i++) send_byte(stim[i], 0);
      check("mid_nwr", 32'(wr_addr.size()), 32'd1);
      check("mid_d0", wr_data[0], 32'h0050_0093);
      do_reset(1);
      check("mid_rst_we", 32'(imem_we), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      wr_addr.delete(); wr_data.delete();
      run_stim(0);
      check("mid_done", 32'(done), 32'd1);
      check("mid_cpu_rst", 32'(cpu_rst), 32'd0);
      check_nominal_writes("mid");
      pulse_reload();
      check("mid_rl_cpu_rst", 32'(cpu_rst), 32'd1);
      check("mid_rl_done", 32'(done), 32'd0);
      check("mid_rl_in_ready", 32'(in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
